// File: rtl/timer_pkg.sv
// Shared types and constants for the timer sequencer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prescale_divider.sv
// Prescale divider: produces one step enable every div+1 running cycles.
module prescale_divider
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  clear,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  en
);

    logic [PRESCALE_W-1:0] ps_cnt;

    assign en = run && (ps_cnt == div);

    // Divider counter: restarts on clear, advances only while running, holds otherwise.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ps_cnt <= '0;
        end else if (clear) begin
            ps_cnt <= '0;
        end else if (run) begin
            if (ps_cnt == div) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Timer sequencer: start/stop controlled up-counter with terminal-count tick.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  cfg_we,
    input  logic [WIDTH-1:0]      cfg_period,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_mode,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic                  tick,
    output logic [WIDTH-1:0]      count
);

    state_t                state;
    state_t                state_next;
    logic [WIDTH-1:0]      period;
    logic [PRESCALE_W-1:0] prescale;
    logic                  mode;
    logic                  start_ok;
    logic                  run;
    logic                  step_en;
    logic                  terminal;

    assign start_ok = (state != ST_RUN) && start && !stop;
    assign run      = (state == ST_RUN) && !stop;
    assign terminal = step_en && (count == period);

    prescale_divider #(
        .PRESCALE_W(PRESCALE_W)
    ) u_divider (
        .CLK  (CLK),
        .RST_N(RST_N),
        .clear(start_ok),
        .run  (run),
        .div  (prescale),
        .en   (step_en)
    );

    // Configuration registers: writable only while not running.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            period   <= '1;
            prescale <= '0;
            mode     <= MODE_ONESHOT;
        end else if (cfg_we && (state != ST_RUN)) begin
            period   <= cfg_period;
            prescale <= cfg_prescale;
            mode     <= cfg_mode;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: stop wins over both start and the terminal event.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (terminal && (mode == MODE_ONESHOT)) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state flops.
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // Count and tick registers: count wraps to zero at the terminal step, tick pulses there.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= terminal;
            if (start_ok) begin
                count <= '0;
            end else if (step_en) begin
                if (count == period) begin
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: vector table, directed corners, random vs model.
module tb_timer_sequencer;

    localparam int WIDTH = 4;
    localparam int PW    = 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             cfg_we = 1'b0;
    logic [WIDTH-1:0] cfg_period = '0;
    logic [PW-1:0]    cfg_prescale = '0;
    logic             cfg_mode = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             busy;
    logic             done;
    logic             tick;
    logic [WIDTH-1:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: tracks cycles elapsed since the run started and derives
    // count and tick arithmetically from period and prescale.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    int m_state, m_period, m_div, m_mode, m_t, m_count, m_tick;

    typedef struct {
        logic       we;
        logic [3:0] per;
        logic [3:0] ps;
        logic       mode;
        logic       start;
        logic       stop;
        logic       e_busy;
        logic       e_done;
        logic       e_tick;
        logic [3:0] e_count;
    } vec_t;

    vec_t vecs[20];

    // Free-running clock.
    always #5 CLK = ~CLK;

    timer_sequencer #(
        .WIDTH     (WIDTH),
        .PRESCALE_W(PW)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .cfg_we      (cfg_we),
        .cfg_period  (cfg_period),
        .cfg_prescale(cfg_prescale),
        .cfg_mode    (cfg_mode),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .done        (done),
        .tick        (tick),
        .count       (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = M_IDLE;
        m_period = 15;
        m_div    = 0;
        m_mode   = 0;
        m_t      = 0;
        m_count  = 0;
        m_tick   = 0;
    endtask

    task automatic model_edge(input logic we, input logic [3:0] per, input logic [3:0] ps,
                              input logic mode, input logic st, input logic sp);
        int n;
        int nt;
        nt = 0;
        if (m_state != M_RUN) begin
            if (we) begin
                m_period = per;
                m_div    = ps;
                m_mode   = mode;
            end
            if (st && !sp) begin
                m_state = M_RUN;
                m_t     = 0;
                m_count = 0;
            end
        end else if (sp) begin
            m_state = M_IDLE;
        end else begin
            m_t++;
            n = (m_period + 1) * (m_div + 1);
            if ((m_t % n) == 0) begin
                nt = 1;
                if (m_mode == 0) m_state = M_DONE;
            end
            m_count = (m_t / (m_div + 1)) % (m_period + 1);
        end
        m_tick = nt;
    endtask

    task automatic checkOutput();
        check("busy",  busy,  (m_state == M_RUN));
        check("done",  done,  (m_state == M_DONE));
        check("tick",  tick,  m_tick);
        check("count", count, m_count);
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] per, input logic [3:0] ps,
                                 input logic mode, input logic st, input logic sp);
        @(negedge CLK);
        cfg_we       = we;
        cfg_period   = per;
        cfg_prescale = ps;
        cfg_mode     = mode;
        start        = st;
        stop         = sp;
        @(posedge CLK);
        model_edge(we, per, ps, mode, st, sp);
        #1;
        checkOutput();
    endtask

    task automatic clear_inputs();
        cfg_we       = 1'b0;
        cfg_period   = '0;
        cfg_prescale = '0;
        cfg_mode     = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
    endtask

    initial begin
        int ticks;
        logic       r_we, r_mode, r_st, r_sp;
        logic [3:0] r_per, r_ps;

        // Hand-computed vectors: short one-shot, DONE behaviour, config lock, slow periodic.
        vecs[0]  = '{1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[2]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
        vecs[3]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
        vecs[4]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[5]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[6]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[7]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[8]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[9]  = '{1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
        vecs[10] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
        vecs[11] = '{1'b1, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[12] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[13] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[14] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[15] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[16] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[17] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        vecs[18] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
        vecs[19] = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};

        // Power-on reset.
        model_reset();
        clear_inputs();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);
        check("rst_tick",  tick,  1'b0);
        check("rst_count", count, 4'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Default config: P=15, D=0, one-shot.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            if (k == 15) check("dflt_count15", count, 4'd15);
        end
        check("dflt_tick16", tick, 1'b1);
        check("dflt_done16", done, 1'b1);
        check("dflt_busy16", busy, 1'b0);
        check("dflt_count16", count, 4'd0);

        // Load a different config, then reset asynchronously mid-run.
        applyStimulus(1'b1, 4'd3, 4'd0, 1'b1, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        clear_inputs();
        #3;
        RST_N = 1'b0;
        #1;
        model_reset();
        check("async_busy",  busy,  1'b0);
        check("async_done",  done,  1'b0);
        check("async_tick",  tick,  1'b0);
        check("async_count", count, 4'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Config must be back to P=15: after 4 steps count is 4, not wrapped.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("cfg_reset_count", count, 4'd4);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("cfg_reset_stop_busy", busy, 1'b0);

        // Table-driven vectors.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].we, vecs[i].per, vecs[i].ps, vecs[i].mode,
                          vecs[i].start, vecs[i].stop);
            check($sformatf("vec%0d_busy", i),  busy,  vecs[i].e_busy);
            check($sformatf("vec%0d_done", i),  done,  vecs[i].e_done);
            check($sformatf("vec%0d_tick", i),  tick,  vecs[i].e_tick);
            check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
        end

        // Stop in the terminal cycle beats the tick.
        applyStimulus(1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("stop_pre_count", count, 4'd5);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("stop_busy",  busy,  1'b0);
        check("stop_done",  done,  1'b0);
        check("stop_tick",  tick,  1'b0);
        check("stop_count", count, 4'd5);

        // Periodic P=3, D=1: tick every 8 cycles, busy throughout.
        applyStimulus(1'b1, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0);
        ticks = 0;
        for (int k = 1; k <= 24; k++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            check($sformatf("per_count%0d", k), count, (k / 2) % 4);
            if (tick) ticks++;
        end
        check("per_ticks", ticks, 3);
        check("per_busy", busy, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

        // P=0, D=0 periodic: tick held high, count stuck at 0.
        applyStimulus(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            check($sformatf("p0_tick%0d", k), tick, 1'b1);
            check($sformatf("p0_count%0d", k), count, 4'd0);
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Simultaneous start and stop in IDLE stays idle.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        check("ss_idle_busy", busy, 1'b0);
        check("ss_idle_done", done, 1'b0);

        // Random traffic against the model.
        for (int k = 0; k < 500; k++) begin
            r_we   = ($urandom_range(0, 7) == 0);
            r_per  = 4'($urandom_range(0, 7));
            r_ps   = 4'($urandom_range(0, 3));
            r_mode = 1'($urandom_range(0, 1));
            r_st   = ($urandom_range(0, 9) == 0);
            r_sp   = ($urandom_range(0, 24) == 0);
            applyStimulus(r_we, r_per, r_ps, r_mode, r_st, r_sp);
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
